// File: rtl/z1_top.sv
// Audio top: an on-chip sequencer streams signed PCM samples through a FWFT FIFO into an I2S transmitter.
// Latency: a sample enters the FIFO one cycle after it is generated. It leaves at the next slot start, with its MSB one SCLK after the LRCK edge.
// Backpressure: the sequencer stalls while the FIFO is full. An empty FIFO at a slot start sends a zero slot and nothing is popped.
//
// Ports:
//   USER_CLK        system clock, all logic on its rising edge
//   RESET           asynchronous active-low reset
//   BUTTONS[0]      restart the sample sequence (debounced); [3:1] unused
//   SWITCHES        unused
//   LEDS            [0] FIFO empty, [1] FIFO full, [2] sequence done, [3] LRCK, [5:4] 0
//   FPGA_SERIAL_RX  unused; FPGA_SERIAL_TX held at 1 (UART idle)
//   MCLK/SCLK/LRCK  codec clocks: USER_CLK/10, USER_CLK/40, SCLK/64
//   SDIN            I2S serial data, MSB first
//   AUDIO_PWM       held at 0
module z1_top #(
  parameter int SYSTEM_CLOCK_FREQ  = 125_000_000,
  parameter int B_SAMPLE_COUNT_MAX = 25000,
  parameter int B_PULSE_COUNT_MAX  = 150,
  parameter int FIFO_DEPTH         = 8,
  parameter int BIT_DEPTH          = 24,
  parameter int SEQ_FIRST          = -50,
  parameter int SEQ_LAST           = 50
) (
  input  logic       USER_CLK,
  input  logic       RESET,
  input  logic [3:0] BUTTONS,
  input  logic [1:0] SWITCHES,
  output logic [5:0] LEDS,
  input  logic       FPGA_SERIAL_RX,
  output logic       FPGA_SERIAL_TX,
  output logic       MCLK,
  output logic       SCLK,
  output logic       LRCK,
  output logic       SDIN,
  output logic       AUDIO_PWM
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int SCW = $clog2(B_SAMPLE_COUNT_MAX + 1);
  localparam int PCW = $clog2(B_PULSE_COUNT_MAX + 1);
  localparam logic [BIT_DEPTH-1:0] SEQ_FIRST_W = BIT_DEPTH'(SEQ_FIRST);
  localparam logic [BIT_DEPTH-1:0] SEQ_LAST_W  = BIT_DEPTH'(SEQ_LAST);
  localparam logic [5:0]           BD6         = 6'(BIT_DEPTH);
  localparam logic [4:0]           MSB_IDX     = 5'(BIT_DEPTH - 1);

  // ---------------- button debouncer ----------------
  logic           btn_meta, btn_sync;
  logic [SCW-1:0] sample_cnt;
  logic [PCW-1:0] pulse_cnt;
  logic           sample_pulse, btn_level, btn_level_q, restart;

  assign sample_pulse = (sample_cnt == SCW'(B_SAMPLE_COUNT_MAX - 1));
  assign btn_level    = (pulse_cnt >= PCW'(B_PULSE_COUNT_MAX));
  assign restart      = btn_level & ~btn_level_q;

  always_ff @(posedge USER_CLK or negedge RESET) begin
    if (!RESET) begin
      btn_meta    <= 1'b0;
      btn_sync    <= 1'b0;
      sample_cnt  <= '0;
      pulse_cnt   <= '0;
      btn_level_q <= 1'b0;
    end else begin
      btn_meta    <= BUTTONS[0];
      btn_sync    <= btn_meta;
      sample_cnt  <= sample_pulse ? '0 : sample_cnt + 1'b1;
      // Counter stops once the threshold is reached, so it never wraps.
      if (!btn_sync)
        pulse_cnt <= '0;
      else if (sample_pulse && !btn_level)
        pulse_cnt <= pulse_cnt + 1'b1;
      btn_level_q <= btn_level;
    end
  end

  // ---------------- sample FIFO (first-word fall-through) ----------------
  logic [BIT_DEPTH-1:0] fifo_mem [FIFO_DEPTH];
  logic [AW:0]          wr_ptr, rd_ptr;
  logic                 fifo_empty, fifo_full, fifo_push, fifo_pop;
  logic [BIT_DEPTH-1:0] fifo_dout;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign fifo_dout  = fifo_mem[rd_ptr[AW-1:0]];

  // ---------------- sequencer ----------------
  logic [BIT_DEPTH-1:0] seq_value;
  logic                 seq_done;

  assign fifo_push = !seq_done && !fifo_full;

  always_ff @(posedge USER_CLK) begin
    if (fifo_push)
      fifo_mem[wr_ptr[AW-1:0]] <= seq_value;
  end

  always_ff @(posedge USER_CLK or negedge RESET) begin
    if (!RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (fifo_push) wr_ptr <= wr_ptr + 1'b1;
      if (fifo_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // A restart overrides the increment; the write of the old value in the same
  // cycle still lands in the FIFO because fifo_push does not look at restart.
  always_ff @(posedge USER_CLK or negedge RESET) begin
    if (!RESET) begin
      seq_value <= SEQ_FIRST_W;
      seq_done  <= 1'b0;
    end else if (restart) begin
      seq_value <= SEQ_FIRST_W;
      seq_done  <= 1'b0;
    end else if (fifo_push) begin
      seq_value <= seq_value + 1'b1;
      if (seq_value == SEQ_LAST_W)
        seq_done <= 1'b1;
    end
  end

  // ---------------- clock generation and I2S transmitter ----------------
  logic [5:0]           presc, presc_next, bit_cnt, bit_next;
  logic [3:0]           mdiv, mdiv_next;
  logic                 sclk_fall, sdin_next;
  logic [4:0]           slot_bit, bit_idx;
  logic [BIT_DEPTH-1:0] left_word, right_word, cur_word, slot_data;

  // mdiv tracks presc mod 10 without a divider; 40 is a multiple of 10.
  assign sclk_fall  = (presc == 6'd39);
  assign presc_next = sclk_fall ? 6'd0 : presc + 6'd1;
  assign mdiv_next  = (mdiv == 4'd9) ? 4'd0 : mdiv + 4'd1;
  assign bit_next   = bit_cnt + 6'd1;

  // The bit sent at new position b is slot bit (b-1), which is simply the old
  // bit_cnt. The channel being loaded at a slot start is never the one being
  // read, so the pre-load registers are safe to use here.
  assign slot_bit  = bit_cnt[4:0];
  assign bit_idx   = MSB_IDX - slot_bit;
  assign cur_word  = bit_cnt[5] ? right_word : left_word;
  assign sdin_next = ({1'b0, slot_bit} < BD6) ? cur_word[bit_idx] : 1'b0;

  assign fifo_pop  = sclk_fall && (bit_next[4:0] == 5'd0) && !fifo_empty;
  assign slot_data = fifo_empty ? '0 : fifo_dout;

  always_ff @(posedge USER_CLK or negedge RESET) begin
    if (!RESET) begin
      presc      <= 6'd0;
      mdiv       <= 4'd0;
      MCLK       <= 1'b0;
      SCLK       <= 1'b0;
      bit_cnt    <= 6'd63;
      LRCK       <= 1'b1;
      SDIN       <= 1'b0;
      left_word  <= '0;
      right_word <= '0;
    end else begin
      presc <= presc_next;
      mdiv  <= mdiv_next;
      MCLK  <= (mdiv_next < 4'd5);
      SCLK  <= (presc_next >= 6'd20);
      if (sclk_fall) begin
        bit_cnt <= bit_next;
        LRCK    <= bit_next[5];
        SDIN    <= sdin_next;
        if (bit_next == 6'd0)  left_word  <= slot_data;
        if (bit_next == 6'd32) right_word <= slot_data;
      end
    end
  end

  // ---------------- fixed outputs ----------------
  assign LEDS           = {2'b00, LRCK, seq_done, fifo_full, fifo_empty};
  assign FPGA_SERIAL_TX = 1'b1;
  assign AUDIO_PWM      = 1'b0;

  logic unused_inputs;
  assign unused_inputs = ^{SWITCHES, BUTTONS[3:1], FPGA_SERIAL_RX, (SYSTEM_CLOCK_FREQ > 0)};

endmodule

// File: tb/tb_z1_top.sv
// Bench for z1_top: directed stimulus pushes expected I2S slots into a queue.
// The monitor rebuilds each 32-bit slot from SDIN on SCLK falls and compares it with the queue.
// SEQ_LAST is shortened to 1 so the full run, drain, restart and reset all fit in a short simulation.
module tb_z1_top;
  logic       USER_CLK = 1'b0;
  logic       RESET = 1'b0;
  logic [3:0] BUTTONS = 4'd0;
  logic [1:0] SWITCHES = 2'd0;
  logic       FPGA_SERIAL_RX = 1'b1;
  logic [5:0] LEDS;
  logic       FPGA_SERIAL_TX, MCLK, SCLK, LRCK, SDIN, AUDIO_PWM;

  always #5 USER_CLK = ~USER_CLK;

  z1_top #(
    .B_SAMPLE_COUNT_MAX(1),
    .B_PULSE_COUNT_MAX (1),
    .SEQ_LAST          (1)
  ) dut (
    .USER_CLK      (USER_CLK),
    .RESET         (RESET),
    .BUTTONS       (BUTTONS),
    .SWITCHES      (SWITCHES),
    .LEDS          (LEDS),
    .FPGA_SERIAL_RX(FPGA_SERIAL_RX),
    .FPGA_SERIAL_TX(FPGA_SERIAL_TX),
    .MCLK          (MCLK),
    .SCLK          (SCLK),
    .LRCK          (LRCK),
    .SDIN          (SDIN),
    .AUDIO_PWM     (AUDIO_PWM)
  );

  typedef struct packed {
    logic        ch;
    logic [23:0] val;
  } slot_t;

  slot_t       exp_q[$];
  slot_t       mon_exp;
  int          checks = 0;
  int          errors = 0;
  int          slot_cnt = 0;
  logic        prev_sclk = 1'b0;
  logic        prev_lrck = 1'b1;
  logic        mon_active = 1'b0;
  logic        mon_ch = 1'b0;
  int          mon_cnt = 0;
  logic [31:0] mon_word = 32'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  task automatic push(input logic ch, input int v);
    exp_q.push_back({ch, 24'(v)});
  endtask

  task automatic tick();
    @(negedge USER_CLK);
    #2;
  endtask

  task automatic wait_slots(input int target, input int budget);
    int n;
    n = 0;
    while (slot_cnt < target && n < budget) begin
      tick();
      n++;
    end
    check("slots_reached", 32'(slot_cnt), 32'(target));
  endtask

  // Monitor: a slot begins on the SCLK fall where LRCK changes and collects the
  // next 32 SDIN bits; the 32nd bit must coincide with the next LRCK change.
  always @(negedge USER_CLK) begin
    if (!RESET) begin
      mon_active = 1'b0;
      mon_cnt    = 0;
    end else if (prev_sclk && !SCLK) begin
      if (mon_active) begin
        mon_word = {mon_word[30:0], SDIN};
        mon_cnt++;
        if (mon_cnt == 32) begin
          mon_active = 1'b0;
          slot_cnt++;
          check("slot_len", 32'(LRCK != mon_ch), 32'd1);
          if (exp_q.size() == 0) begin
            check("slot_unexpected", 32'(exp_q.size()), 32'd1);
          end else begin
            mon_exp = exp_q.pop_front();
            check("slot_data", mon_word, {mon_exp.val, 8'h00});
            check("slot_channel", 32'(mon_ch), 32'(mon_exp.ch));
          end
        end
      end
      if (LRCK != prev_lrck) begin
        if (mon_active) check("slot_len_short", 32'(mon_cnt), 32'd32);
        mon_active = 1'b1;
        mon_cnt    = 0;
        mon_ch     = LRCK;
        mon_word   = 32'd0;
      end
    end
    prev_sclk = SCLK;
    prev_lrck = LRCK;
  end

  initial begin
    int  mclk_bad;
    int  sclk_bad;
    int  n;
    logic found;
    mclk_bad = 0;
    sclk_bad = 0;

    // Reset state
    RESET = 1'b0;
    repeat (10) tick();
    check("rst_mclk", 32'(MCLK), 32'd0);
    check("rst_sclk", 32'(SCLK), 32'd0);
    check("rst_sdin", 32'(SDIN), 32'd0);
    check("rst_lrck", 32'(LRCK), 32'd1);
    check("rst_leds", 32'(LEDS), 32'h09);

    // Main run: -50..1 alternating L/R, then two drained zero slots
    for (int v = -50; v <= 1; v++) push(((v + 50) % 2) == 1, v);
    push(1'b0, 0);
    push(1'b1, 0);

    RESET = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (MCLK !== (((k % 40) % 10) < 5)) mclk_bad++;
      if (SCLK !== ((k % 40) >= 20)) sclk_bad++;
      if (k == 10) begin
        check("fifo_full_after_fill", 32'(LEDS[1]), 32'd1);
        check("fifo_not_empty_after_fill", 32'(LEDS[0]), 32'd0);
      end
      if (k == 39) check("lrck_before_first_fall", 32'(LRCK), 32'd1);
    end
    check("mclk_pattern", 32'(mclk_bad), 32'd0);
    check("sclk_pattern", 32'(sclk_bad), 32'd0);
    check("lrck_at_first_fall", 32'(LRCK), 32'd0);

    wait_slots(54, 75000);
    check("seq_done_led", 32'(LEDS[2]), 32'd1);
    check("fifo_empty_led", 32'(LEDS[0]), 32'd1);
    check("queue_after_run", 32'(exp_q.size()), 32'd0);

    // Restart: the left slot in progress stays zero, and the next slot carries -50.
    push(1'b0, 0);
    push(1'b1, -50);
    BUTTONS = 4'b0001;
    repeat (5) tick();
    BUTTONS = 4'b0000;
    repeat (5) tick();
    check("restart_clears_done", 32'(LEDS[2]), 32'd0);

    // Reset at b=10 of the following left slot
    n = 0;
    found = 1'b0;
    while (!found && n < 4000) begin
      tick();
      n++;
      found = (slot_cnt == 56) && mon_active && !mon_ch && (mon_cnt == 10);
    end
    check("reach_mid_left_slot", 32'(found), 32'd1);
    RESET = 1'b0;
    #1;
    check("midrst_mclk", 32'(MCLK), 32'd0);
    check("midrst_sclk", 32'(SCLK), 32'd0);
    check("midrst_sdin", 32'(SDIN), 32'd0);
    check("midrst_lrck", 32'(LRCK), 32'd1);
    check("midrst_leds", 32'(LEDS), 32'h09);

    push(1'b0, -50);
    push(1'b1, -49);
    repeat (5) tick();
    RESET = 1'b1;
    wait_slots(58, 4000);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
